// File: rtl/port_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : port_uart_tx
//  Purpose  : Buffers port-write bytes in a small FIFO and sends them as 8N1
//             UART frames, with a pollable status byte for the CPU.
//  Revision : 1.0  initial release
// ============================================================================
module port_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int CW           = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          ovf_clr,
    output logic          tx,
    output logic          full,
    output logic          busy,
    output logic          overflow,
    output logic [CW-1:0] count,
    output logic [7:0]    status
);

    localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]       c_DEPTH     = CW'(FIFO_DEPTH);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;
    localparam logic [1:0] c_S_STOP  = 2'd3;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wptr;
    logic [c_PTR_W-1:0]  r_rptr;
    logic [CW-1:0]       r_count;
    logic                r_ovf;
    logic [1:0]          r_state;
    logic [c_BAUD_W-1:0] r_baud;
    logic [2:0]          r_bit;
    logic [7:0]          r_shift;
    logic                r_tx;

    logic w_full;
    logic w_nonempty;
    logic w_baud_end;
    logic w_pop;
    logic w_accept;
    logic w_drop;
    logic w_busy;

    assign w_full     = (r_count == c_DEPTH);
    assign w_nonempty = (r_count != '0);
    assign w_baud_end = (r_baud == c_BAUD_LAST);
    // A pop happens only when the serializer is ready for a new frame.
    assign w_pop      = w_nonempty &&
                        ((r_state == c_S_IDLE) || ((r_state == c_S_STOP) && w_baud_end));
    assign w_accept   = wr_en && (!w_full || w_pop);
    assign w_drop     = wr_en && w_full && !w_pop;
    assign w_busy     = (r_state != c_S_IDLE) || w_nonempty;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_state <= c_S_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end

            case (r_state)
                c_S_IDLE: begin
                    r_baud <= '0;
                    r_tx   <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
                        r_tx    <= 1'b0;
                        r_state <= c_S_START;
                    end
                end
                c_S_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_bit   <= 3'd0;
                        r_tx    <= r_shift[0];
                        r_state <= c_S_DATA;
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end
                c_S_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= c_S_STOP;
                        end else begin
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                            r_bit   <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end
                default: begin
                    // Stop bit: chain straight into the next start bit if data waits.
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= r_mem[r_rptr];
                            r_tx    <= 1'b0;
                            r_state <= c_S_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= c_S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end
            endcase
        end
    end

    assign tx       = r_tx;
    assign full     = w_full;
    assign busy     = w_busy;
    assign overflow = r_ovf;
    assign count    = r_count;
    assign status   = {5'b00000, r_ovf, w_busy, w_full};

endmodule
`default_nettype wire

// File: tb/tb_port_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_port_uart_tx
//  Purpose  : Directed bench for port_uart_tx with a frame-decoding scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_port_uart_tx;

    localparam int CLKS_PER_BIT = 4;
    localparam int FIFO_DEPTH   = 4;
    localparam int CW           = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          ovf_clr;
    logic          tx;
    logic          full;
    logic          busy;
    logic          overflow;
    logic [CW-1:0] count;
    logic [7:0]    status;

    int         checks = 0;
    int         errors = 0;
    int         frames = 0;
    logic [7:0] sb[$];

    port_uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CW           (CW)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .ovf_clr  (ovf_clr),
        .tx       (tx),
        .full     (full),
        .busy     (busy),
        .overflow (overflow),
        .count    (count),
        .status   (status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy !== 1'b0 && n < max_cycles) begin
            tick();
            n++;
        end
        chk("drain_busy", 32'(busy), 32'd0);
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    // Frame decoder: samples each bit at negedges near its middle.
    int         mcnt = 0;
    bit         mact = 1'b0;
    logic [7:0] mbyte = 8'd0;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            mact = 1'b0;
        end else if (!mact) begin
            if (tx === 1'b0) begin
                mact = 1'b1;
                mcnt = 0;
            end
        end else begin
            mcnt++;
            if (mcnt == 1) begin
                chk("start_bit", 32'(tx), 32'd0);
            end else if (mcnt >= 5 && mcnt <= 33 && ((mcnt - 1) % 4) == 0) begin
                mbyte[3'((mcnt - 5) / 4)] = tx;
            end else if (mcnt == 37) begin
                chk("stop_bit", 32'(tx), 32'd1);
                frames++;
                chk("frame_pending", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    chk("frame_byte", 32'(mbyte), 32'(sb.pop_front()));
                end
            end else if (mcnt == 39) begin
                mact = 1'b0;
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'd0;
        ovf_clr = 1'b0;

        // Reset
        ticks(3);
        chk("rst_tx_held", 32'(tx), 32'd1);
        rst_n = 1'b1;
        tick();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_status", 32'(status), 32'h00);

        // Single byte 0xA5
        sb.push_back(8'hA5);
        write_byte(8'hA5);
        chk("t2_count_n", 32'(count), 32'd1);
        chk("t2_tx_n", 32'(tx), 32'd1);
        chk("t2_busy_n", 32'(busy), 32'd1);
        tick();
        chk("t2_tx_start", 32'(tx), 32'd0);
        chk("t2_count_pop", 32'(count), 32'd0);
        ticks(3);
        chk("t2_tx_start_end", 32'(tx), 32'd0);
        tick();
        chk("t2_tx_bit0", 32'(tx), 32'd1);
        ticks(4);
        chk("t2_tx_bit1", 32'(tx), 32'd0);
        ticks(31);
        chk("t2_busy_n40", 32'(busy), 32'd1);
        chk("t2_tx_stop", 32'(tx), 32'd1);
        tick();
        chk("t2_busy_n41", 32'(busy), 32'd0);
        chk("t2_frames", 32'(frames), 32'd1);

        // Back-to-back 0x01, 0x80
        sb.push_back(8'h01);
        sb.push_back(8'h80);
        wr_en   = 1'b1;
        wr_data = 8'h01;
        tick();
        chk("t3_count_n", 32'(count), 32'd1);
        wr_data = 8'h80;
        tick();
        wr_en = 1'b0;
        chk("t3_count_n1", 32'(count), 32'd1);
        chk("t3_tx_start1", 32'(tx), 32'd0);
        ticks(39);
        chk("t3_tx_stop1", 32'(tx), 32'd1);
        chk("t3_count_n40", 32'(count), 32'd1);
        tick();
        chk("t3_tx_start2", 32'(tx), 32'd0);
        chk("t3_count_n41", 32'(count), 32'd0);
        chk("t3_busy_n41", 32'(busy), 32'd1);
        wait_idle(200);
        chk("t3_frames", 32'(frames), 32'd3);

        // Fill and overflow
        sb.push_back(8'h11);
        write_byte(8'h11);
        tick();
        sb.push_back(8'h22); write_byte(8'h22);
        sb.push_back(8'h33); write_byte(8'h33);
        sb.push_back(8'h44); write_byte(8'h44);
        sb.push_back(8'h55); write_byte(8'h55);
        chk("t4_full", 32'(full), 32'd1);
        chk("t4_count_full", 32'(count), 32'd4);
        chk("t4_ovf_pre", 32'(overflow), 32'd0);
        write_byte(8'h66);
        chk("t4_count_drop", 32'(count), 32'd4);
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_status_full", 32'(status), 32'h07);
        ticks(35);
        chk("t4_count_pop", 32'(count), 32'd3);
        chk("t4_status_tx", 32'(status), 32'h06);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t4_status_clr", 32'(status), 32'h02);
        wait_idle(400);
        chk("t4_frames", 32'(frames), 32'd8);

        // Write while full on the STOP->START pop edge
        sb.push_back(8'hAA);
        sb.push_back(8'hB1);
        sb.push_back(8'hB2);
        sb.push_back(8'hB3);
        sb.push_back(8'hB4);
        wr_en = 1'b1;
        wr_data = 8'hAA; tick();
        wr_data = 8'hB1; tick();
        wr_data = 8'hB2; tick();
        wr_data = 8'hB3; tick();
        wr_data = 8'hB4; tick();
        wr_en = 1'b0;
        chk("t5_count_full", 32'(count), 32'd4);
        chk("t5_full", 32'(full), 32'd1);
        ticks(36);
        chk("t5_tx_stop", 32'(tx), 32'd1);
        chk("t5_count_pre", 32'(count), 32'd4);
        sb.push_back(8'hB5);
        write_byte(8'hB5);
        chk("t5_count_same", 32'(count), 32'd4);
        chk("t5_ovf_none", 32'(overflow), 32'd0);
        chk("t5_tx_start", 32'(tx), 32'd0);
        wait_idle(600);
        chk("t5_frames", 32'(frames), 32'd14);

        // Reset mid-frame during data bit 3 of 0xF0
        sb.push_back(8'hF0);
        write_byte(8'hF0);
        ticks(18);
        chk("t6_tx_bit3", 32'(tx), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tx", 32'(tx), 32'd1);
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        sb.delete();
        ticks(2);
        rst_n = 1'b1;
        tick();
        sb.push_back(8'h3C);
        write_byte(8'h3C);
        tick();
        chk("t6_tx_start", 32'(tx), 32'd0);
        wait_idle(200);
        chk("t6_frames", 32'(frames), 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/port_uart_tx.md
Name: port_uart_tx

Overview:
Output-side serial peripheral that sits directly downstream of the processor's memory-mapped output port.
- Accepts byte writes strobed by the port-write decode (PortSel & MemWrite) and buffers them in a small FIFO.
- Serializes each byte as 8N1 UART frames on a single tx line.
- Returns a status byte that the input-port path can read back, so software can poll for full, busy and overflow before storing.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range >= 2
FIFO_DEPTH, 4, byte entries in the transmit FIFO; power of 2, >= 2
CW, 3, count width, equal to log2(FIFO_DEPTH)+1

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
wr_en  input  1  one-cycle write strobe from the port decode (PortSel & MemWrite)
wr_data  input  8  byte to transmit (WriteData[7:0])
ovf_clr  input  1  one-cycle pulse that clears the sticky overflow flag
tx  output  1  serial line; idles high
full  output  1  FIFO holds FIFO_DEPTH bytes
busy  output  1  frame in progress or FIFO not empty
overflow  output  1  sticky flag: a write was dropped
count  output  CW  current FIFO occupancy
status  output  8  {5'b0, overflow, busy, full}, for CPU read-back

Behaviour:
- Reset (reset=0, asynchronous): tx=1, FIFO empty (count=0), full=0, busy=0, overflow=0, FSM=IDLE, baud counter=0, bit index=0. Reset asserted mid-frame returns tx to 1 without waiting for a clock edge; the partial frame is abandoned.
- FIFO: circular buffer with read/write pointers wrapping modulo FIFO_DEPTH.
  - count rises on accepted write only, falls on pop only, unchanged on both.
  - full = (count==FIFO_DEPTH).
- Write acceptance: a write is accepted if wr_en=1 and (full=0 or a pop occurs in the same cycle).
  - Full and pop in the same cycle: the write is accepted and count stays FIFO_DEPTH.
  - Full and no pop: the byte is dropped and overflow is set on that edge.
- overflow: cleared by ovf_clr. If ovf_clr and a dropped write occur in the same cycle, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count!=0, pop at this edge, load the byte into the shift register, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0]; 8 bits are sent LSB first, each held CLKS_PER_BIT cycles. Shift right at each bit end. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end: if count!=0, pop and go directly to START (no idle gap between frames); otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, with the terminal value marking the end of the current bit; it is zero on every state entry.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Latency:
  - wr_en sampled at edge N gives count=1 after N.
  - The pop occurs at edge N+1 (IDLE sees non-empty); tx drops to 0 after edge N+1.
  - The FIFO is not fall-through: first-bit latency is 2 edges.
- busy = (FSM!=IDLE) | (count!=0). It deasserts on the edge where STOP exits to IDLE with the FIFO empty.
- tx, full, busy, overflow and count are all registered or derived only from registers; there is no combinational path from wr_en to tx.

Test Plan:
1. Reset, CLKS_PER_BIT=4: hold reset=0 for 3 cycles, then release → tx=1, full=0, busy=0, overflow=0, count=0, status=8'h00.
2. Single byte, CLKS_PER_BIT=4: write 8'hA5 at edge N → tx low from N+1 for 4 cycles. Data bits are then 1,0,1,0,0,1,0,1 at 4 cycles each, followed by stop=1 for 4 cycles. busy=0 after edge N+41; total frame is 40 cycles.
3. Back-to-back: write 8'h01 then 8'h80 on consecutive cycles → two frames with no idle cycle between them. The second start bit begins the cycle after the first stop bit ends; count peaks at 1.
4. Full/overflow, FIFO_DEPTH=4: while frame 1 (8'h11) is sending, write 8'h22, 8'h33, 8'h44, 8'h55, 8'h66 → full=1 after the 4th, 8'h66 is dropped, overflow=1. Output is 11,22,33,44,55; status=8'h06 during transmission, then ovf_clr → status bit 2 clears.
5. Simultaneous write and pop while full: time a write to the STOP→START pop edge with count=4 → write accepted, count stays 4, no overflow.
6. Reset mid-frame: assert reset=0 during DATA bit 3 of 8'hF0 → tx=1 immediately, count=0, busy=0. After release, a new write of 8'h3C transmits cleanly with a correct start bit.
